// File: rtl/conv_pkg.sv
// conv_pkg: shared state encodings and default widths for the conv output writeback path
package conv_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DIM_WIDTH  = 10;
    localparam int DEF_ELEM_BYTES = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DRAIN} main_state_t;
    typedef enum logic [1:0] {WB_IDLE, WB_POP, WB_WRITE} wb_state_t;
endpackage

// File: rtl/conv_output_writeback_sched_addr_gen.sv
// conv_out_addr_gen: walks (channel,row,col) and produces byte addresses with incremental pitch adders
// Ports: clk/rst; i_load latches base, dimensions and pitches and rewinds the walk;
// i_advance steps to the next element; o_addr is the current element address;
// o_last flags the final element of the tensor.
module conv_out_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
    parameter int ELEM_BYTES = DEF_ELEM_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [DIM_WIDTH-1:0]  i_out_w,
    input  logic [DIM_WIDTH-1:0]  i_out_h,
    input  logic [DIM_WIDTH-1:0]  i_out_ch,
    input  logic [ADDR_WIDTH-1:0] i_row_pitch,
    input  logic [ADDR_WIDTH-1:0] i_plane_pitch,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);
    localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

    logic [DIM_WIDTH-1:0]  r_w, r_h, r_c, r_col, r_row, r_ch;
    logic [ADDR_WIDTH-1:0] r_rp, r_pp, r_addr, r_row_start, r_plane_start;
    logic                  w_end_col, w_end_row, w_end_ch;
    logic [ADDR_WIDTH-1:0] w_next_row, w_next_plane;

    assign w_end_col    = r_col == r_w - ONE;
    assign w_end_row    = r_row == r_h - ONE;
    assign w_end_ch     = r_ch == r_c - ONE;
    assign w_next_row   = r_row_start + r_rp;
    assign w_next_plane = r_plane_start + r_pp;
    assign o_addr       = r_addr;
    assign o_last       = w_end_col & w_end_row & w_end_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w           <= '0;
            r_h           <= '0;
            r_c           <= '0;
            r_rp          <= '0;
            r_pp          <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_ch          <= '0;
            r_addr        <= '0;
            r_row_start   <= '0;
            r_plane_start <= '0;
        end else if (i_load) begin
            r_w           <= i_out_w;
            r_h           <= i_out_h;
            r_c           <= i_out_ch;
            r_rp          <= i_row_pitch;
            r_pp          <= i_plane_pitch;
            r_col         <= '0;
            r_row         <= '0;
            r_ch          <= '0;
            r_addr        <= i_base;
            r_row_start   <= i_base;
            r_plane_start <= i_base;
        end else if (i_advance) begin
            if (!w_end_col) begin
                r_col  <= r_col + ONE;
                r_addr <= r_addr + ADDR_WIDTH'(ELEM_BYTES);
            end else if (!w_end_row) begin
                r_col       <= '0;
                r_row       <= r_row + ONE;
                r_row_start <= w_next_row;
                r_addr      <= w_next_row;
            end else begin
                // new plane: row start and element address both restart at the plane origin
                r_col         <= '0;
                r_row         <= '0;
                r_ch          <= r_ch + ONE;
                r_plane_start <= w_next_plane;
                r_row_start   <= w_next_plane;
                r_addr        <= w_next_plane;
            end
        end
    end
endmodule

// File: rtl/conv_output_writeback_sched.sv
// conv_output_writeback_sched: pushes output addresses into the address FIFO and writes results back to memory
// Ports: clk/rst; i_start + i_cfg_* launch a layer; o_aq_push/o_aq_addr feed the external
// address FIFO, o_aq_pop/i_aq_out_addr drain it; i_res_* / o_res_ready accept results;
// o_wr_* / i_wr_ready is the memory write port; o_busy while running, o_done one-cycle pulse.
module conv_output_writeback_sched
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
    parameter int Q_DEPTH    = 16,
    parameter int ELEM_BYTES = DEF_ELEM_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_cfg_base,
    input  logic [DIM_WIDTH-1:0]  i_cfg_out_w,
    input  logic [DIM_WIDTH-1:0]  i_cfg_out_h,
    input  logic [DIM_WIDTH-1:0]  i_cfg_out_ch,
    input  logic [ADDR_WIDTH-1:0] i_cfg_row_pitch,
    input  logic [ADDR_WIDTH-1:0] i_cfg_plane_pitch,
    output logic                  o_aq_push,
    output logic [ADDR_WIDTH-1:0] o_aq_addr,
    output logic                  o_aq_pop,
    input  logic [ADDR_WIDTH-1:0] i_aq_out_addr,
    input  logic                  i_res_valid,
    input  logic [DATA_WIDTH-1:0] i_res_data,
    output logic                  o_res_ready,
    output logic                  o_wr_valid,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_wr_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int OW = $clog2(Q_DEPTH + 1);
    localparam int CW = 3 * DIM_WIDTH;

    main_state_t           r_state, w_state_nxt;
    wb_state_t             r_wb, w_wb_nxt;
    logic [OW-1:0]         r_occ;
    logic [CW-1:0]         r_push_cnt, r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_done;
    logic                  w_start, w_zero, w_last, w_accept, w_fin;

    conv_out_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DIM_WIDTH (DIM_WIDTH),
        .ELEM_BYTES(ELEM_BYTES)
    ) u_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_start),
        .i_base       (i_cfg_base),
        .i_out_w      (i_cfg_out_w),
        .i_out_h      (i_cfg_out_h),
        .i_out_ch     (i_cfg_out_ch),
        .i_row_pitch  (i_cfg_row_pitch),
        .i_plane_pitch(i_cfg_plane_pitch),
        .i_advance    (o_aq_push),
        .o_addr       (o_aq_addr),
        .o_last       (w_last)
    );

    assign w_start     = (r_state == ST_IDLE) & i_start;
    assign w_zero      = (i_cfg_out_w == '0) | (i_cfg_out_h == '0) | (i_cfg_out_ch == '0);
    assign o_aq_push   = (r_state == ST_GEN) & (r_occ < OW'(Q_DEPTH));
    assign o_res_ready = (r_state != ST_IDLE) & (r_wb == WB_IDLE) & (r_occ != '0);
    assign o_aq_pop    = i_res_valid & o_res_ready;
    assign w_accept    = (r_wb == WB_WRITE) & i_wr_ready;
    // every element has been pushed once in DRAIN, so the push count is the element total
    assign w_fin       = (r_state == ST_DRAIN) & w_accept & (r_wr_cnt + CW'(1) == r_push_cnt);
    assign o_wr_valid  = r_wb == WB_WRITE;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = r_state != ST_IDLE;
    assign o_done      = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start && !w_zero) w_state_nxt = ST_GEN;
            ST_GEN:   if (o_aq_push && w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_fin) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wb_nxt = r_wb;
        case (r_wb)
            WB_IDLE:  if (o_aq_pop) w_wb_nxt = WB_POP;
            WB_POP:   w_wb_nxt = WB_WRITE;
            WB_WRITE: if (i_wr_ready) w_wb_nxt = WB_IDLE;
            default:  w_wb_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wb       <= WB_IDLE;
            r_occ      <= '0;
            r_push_cnt <= '0;
            r_wr_cnt   <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wb    <= w_wb_nxt;
            r_occ   <= r_occ + OW'(o_aq_push) - OW'(o_aq_pop);
            r_done  <= (w_start & w_zero) | w_fin;
            if (w_start) begin
                r_push_cnt <= '0;
                r_wr_cnt   <= '0;
            end else begin
                r_push_cnt <= r_push_cnt + CW'(o_aq_push);
                r_wr_cnt   <= r_wr_cnt + CW'(w_accept);
            end
            if (o_aq_pop) r_wr_data <= i_res_data;
            if (r_wb == WB_POP) r_wr_addr <= i_aq_out_addr;
        end
    end
endmodule

// File: tb/tb_conv_output_writeback_sched.sv
// tb_conv_output_writeback_sched: directed self-checking bench with an address FIFO model
module tb_conv_output_writeback_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_cfg_base;
    logic [9:0]  i_cfg_out_w, i_cfg_out_h, i_cfg_out_ch;
    logic [31:0] i_cfg_row_pitch, i_cfg_plane_pitch;
    logic        o_aq_push, o_aq_pop, o_res_ready, o_wr_valid, o_busy, o_done;
    logic [31:0] o_aq_addr, o_wr_addr, o_wr_data;
    logic [31:0] i_aq_out_addr = '0;
    logic        i_res_valid;
    logic [31:0] i_res_data;
    logic        i_wr_ready;

    int vec_n = 0, err_n = 0, cyc = 0;
    int ridx = 0, ridx_n = 0, pop_n = 0, done_n = 0, occ_m = 0, occ_max = 0;
    logic [31:0] fq[$];
    logic [31:0] push_a[$], wr_a[$], wr_d[$];
    int          push_c[$];

    always #5 clk = ~clk;

    conv_output_writeback_sched #(.Q_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_cfg_base       (i_cfg_base),
        .i_cfg_out_w      (i_cfg_out_w),
        .i_cfg_out_h      (i_cfg_out_h),
        .i_cfg_out_ch     (i_cfg_out_ch),
        .i_cfg_row_pitch  (i_cfg_row_pitch),
        .i_cfg_plane_pitch(i_cfg_plane_pitch),
        .o_aq_push        (o_aq_push),
        .o_aq_addr        (o_aq_addr),
        .o_aq_pop         (o_aq_pop),
        .i_aq_out_addr    (i_aq_out_addr),
        .i_res_valid      (i_res_valid),
        .i_res_data       (i_res_data),
        .o_res_ready      (o_res_ready),
        .o_wr_valid       (o_wr_valid),
        .o_wr_addr        (o_wr_addr),
        .o_wr_data        (o_wr_data),
        .i_wr_ready       (i_wr_ready),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    // result source: n-th consumed result carries 0xA000+n
    assign i_res_data = 32'hA000 + 32'(ridx);

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        ridx <= ridx_n;
    end

    // mid-cycle monitor and address FIFO model
    always @(negedge clk) begin
        if (rst) begin
            fq.delete();
            occ_m = 0;
        end else begin
            if (o_aq_pop) begin
                i_aq_out_addr <= fq.pop_front();
                pop_n++;
                ridx_n++;
            end
            if (o_aq_push) begin
                fq.push_back(o_aq_addr);
                push_a.push_back(o_aq_addr);
                push_c.push_back(cyc);
            end
            occ_m += int'(o_aq_push) - int'(o_aq_pop);
            if (occ_m > occ_max) occ_max = occ_m;
            if (o_wr_valid && i_wr_ready) begin
                wr_a.push_back(o_wr_addr);
                wr_d.push_back(o_wr_data);
            end
            if (o_done) done_n++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] base, input int w, input int h, input int c,
                       input logic [31:0] rp, input logic [31:0] pp);
        i_cfg_base        = base;
        i_cfg_out_w       = 10'(w);
        i_cfg_out_h       = 10'(h);
        i_cfg_out_ch      = 10'(c);
        i_cfg_row_pitch   = rp;
        i_cfg_plane_pitch = pp;
        i_start           = 1'b1;
        tick();
        i_start           = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (o_done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(k < budget), 64'd1);
    endtask

    function automatic logic [31:0] ea(input logic [31:0] base, input int i, input int w, input int h,
                                       input logic [31:0] rp, input logic [31:0] pp);
        int c, r, ch;
        c  = i % w;
        r  = (i / w) % h;
        ch = i / (w * h);
        return base + 32'(ch) * pp + 32'(r) * rp + 32'(c) * 32'd4;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_push"}, 64'(o_aq_push), 64'd0);
        chk({tag, "_pop"}, 64'(o_aq_pop), 64'd0);
        chk({tag, "_rdy"}, 64'(o_res_ready), 64'd0);
        chk({tag, "_wrv"}, 64'(o_wr_valid), 64'd0);
        chk({tag, "_aqaddr"}, 64'(o_aq_addr), 64'd0);
        chk({tag, "_wraddr"}, 64'(o_wr_addr), 64'd0);
        chk({tag, "_wrdata"}, 64'(o_wr_data), 64'd0);
    endtask

    task automatic chk_walk(input string tag, input int p0, input int w0, input int r0, input int n,
                            input logic [31:0] base, input int w, input int h,
                            input logic [31:0] rp, input logic [31:0] pp);
        chk({tag, "_npush"}, 64'(push_a.size() - p0), 64'(n));
        chk({tag, "_nwr"}, 64'(wr_a.size() - w0), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (p0 + i < push_a.size()) chk($sformatf("%s_push%0d", tag, i), 64'(push_a[p0 + i]), 64'(ea(base, i, w, h, rp, pp)));
            if (w0 + i < wr_a.size()) begin
                chk($sformatf("%s_wa%0d", tag, i), 64'(wr_a[w0 + i]), 64'(ea(base, i, w, h, rp, pp)));
                chk($sformatf("%s_wd%0d", tag, i), 64'(wr_d[w0 + i]), 64'(32'hA000 + 32'(r0 + i)));
            end
        end
    endtask

    initial begin
        int p0, w0, d0, r0, q0, s, k;
        rst = 1'b1;
        i_start = 1'b0;
        i_cfg_base = '0;
        i_cfg_out_w = '0;
        i_cfg_out_h = '0;
        i_cfg_out_ch = '0;
        i_cfg_row_pitch = '0;
        i_cfg_plane_pitch = '0;
        i_res_valid = 1'b0;
        i_wr_ready = 1'b1;
        tick(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // basic walk 2x2x1
        i_res_valid = 1'b1;
        p0 = push_a.size(); w0 = wr_a.size(); d0 = done_n; r0 = ridx; s = cyc;
        run(32'h1000, 2, 2, 1, 32'd8, 32'd16);
        chk("basic_busy_c1", 64'(o_busy), 64'd1);
        chk("basic_push_c1", 64'(o_aq_push), 64'd1);
        chk("basic_addr_c1", 64'(o_aq_addr), 64'h1000);
        wait_done(100, "basic");
        chk("basic_busy_at_done", 64'(o_busy), 64'd0);
        tick();
        chk("basic_done_pulse", 64'(o_done), 64'd0);
        chk_walk("basic", p0, w0, r0, 4, 32'h1000, 2, 2, 32'd8, 32'd16);
        for (int i = 0; i < 4; i++)
            if (p0 + i < push_c.size()) chk($sformatf("basic_pcyc%0d", i), 64'(push_c[p0 + i] - s), 64'(i + 1));
        chk("basic_ndone", 64'(done_n - d0), 64'd1);

        // FIFO full with Q_DEPTH=4, results withheld
        i_res_valid = 1'b0;
        p0 = push_a.size(); w0 = wr_a.size(); r0 = ridx; q0 = pop_n;
        run(32'h2000, 3, 3, 1, 32'h40, 32'h200);
        tick(12);
        chk("full_npush", 64'(push_a.size() - p0), 64'd4);
        chk("full_push_low", 64'(o_aq_push), 64'd0);
        chk("full_rdy", 64'(o_res_ready), 64'd1);
        i_res_valid = 1'b1;
        tick();
        i_res_valid = 1'b0;
        tick(4);
        chk("full_npop", 64'(pop_n - q0), 64'd1);
        chk("full_npush_after1", 64'(push_a.size() - p0), 64'd5);
        chk("full_push_low2", 64'(o_aq_push), 64'd0);
        i_res_valid = 1'b1;
        wait_done(300, "full");
        chk_walk("full", p0, w0, r0, 9, 32'h2000, 3, 3, 32'h40, 32'h200);
        chk("full_occ_max", 64'(occ_max <= 4), 64'd1);
        tick();

        // write backpressure
        i_wr_ready = 1'b0;
        p0 = push_a.size(); w0 = wr_a.size(); r0 = ridx;
        run(32'h3000, 2, 1, 1, 32'd0, 32'd0);
        k = 0;
        while (o_wr_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("bp_wrv_seen", 64'(k < 20), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_wrv%0d", i), 64'(o_wr_valid), 64'd1);
            chk($sformatf("bp_wa%0d", i), 64'(o_wr_addr), 64'h3000);
            chk($sformatf("bp_wd%0d", i), 64'(o_wr_data), 64'(32'hA000 + 32'(r0)));
            chk($sformatf("bp_rdy%0d", i), 64'(o_res_ready), 64'd0);
        end
        i_wr_ready = 1'b1;
        tick();
        chk("bp_rdy_after", 64'(o_res_ready), 64'd1);
        wait_done(100, "bp");
        chk_walk("bp", p0, w0, r0, 2, 32'h3000, 2, 1, 32'd0, 32'd0);
        tick();

        // zero dimension
        p0 = push_a.size(); q0 = pop_n; d0 = done_n;
        run(32'h4000, 2, 0, 1, 32'd8, 32'd16);
        chk("zero_done_c1", 64'(o_done), 64'd1);
        chk("zero_busy_c1", 64'(o_busy), 64'd0);
        tick(3);
        chk("zero_npush", 64'(push_a.size() - p0), 64'd0);
        chk("zero_npop", 64'(pop_n - q0), 64'd0);
        chk("zero_ndone", 64'(done_n - d0), 64'd1);

        // start while busy is ignored
        p0 = push_a.size(); w0 = wr_a.size(); r0 = ridx; d0 = done_n;
        run(32'h4000, 2, 2, 1, 32'd8, 32'd16);
        tick(2);
        i_cfg_base = 32'h5000;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(100, "sbusy");
        tick(5);
        chk_walk("sbusy", p0, w0, r0, 4, 32'h4000, 2, 2, 32'd8, 32'd16);
        chk("sbusy_ndone", 64'(done_n - d0), 64'd1);
        chk("sbusy_idle", 64'(o_busy), 64'd0);

        // multi-channel 2x1x2
        p0 = push_a.size(); w0 = wr_a.size(); r0 = ridx;
        run(32'h6000, 2, 1, 2, 32'h10, 32'h100);
        wait_done(100, "mch");
        chk_walk("mch", p0, w0, r0, 4, 32'h6000, 2, 1, 32'h10, 32'h100);
        if (p0 + 3 < push_a.size()) chk("mch_last_lit", 64'(push_a[p0 + 3]), 64'h6104);
        tick();

        // reset mid-run after three writes
        w0 = wr_a.size();
        run(32'h7000, 2, 2, 2, 32'd8, 32'h40);
        k = 0;
        while (wr_a.size() - w0 < 3 && k < 100) begin
            tick();
            k++;
        end
        chk("mid_3wr_seen", 64'(k < 100), 64'd1);
        rst = 1'b1;
        tick();
        chk_outputs_zero("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_idle", 64'(o_busy), 64'd0);
        p0 = push_a.size(); w0 = wr_a.size(); r0 = ridx;
        run(32'h7000, 2, 2, 2, 32'd8, 32'h40);
        chk("restart_push", 64'(o_aq_push), 64'd1);
        chk("restart_addr", 64'(o_aq_addr), 64'h7000);
        wait_done(200, "restart");
        chk_walk("restart", p0, w0, r0, 8, 32'h7000, 2, 2, 32'd8, 32'h40);
        chk("final_occ_max", 64'(occ_max <= 4), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end
endmodule

// File: doc/conv_output_writeback_sched.md
# conv_output_writeback_sched

Sequencer for the convolution layer's output path: on `start` it walks the output tensor (channel, row, column) and pushes one byte address per output element into the output address FIFO, throttled by a local occupancy count. As the convolution datapath delivers results, it pops the matching address and issues one memory write per element. It pulses `done` after the last write is accepted.

## Interface
- `ADDR_WIDTH`, 32, byte address width; must match the address FIFO.
- `DATA_WIDTH`, 32, result word width.
- `DIM_WIDTH`, 10, width of each output dimension.
- `Q_DEPTH`, 16, capacity of the external address FIFO.
- `ELEM_BYTES`, 4, address step between adjacent columns.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a layer; sampled only in IDLE.
- `cfg_base` in ADDR_WIDTH: address of element (0,0,0).
- `cfg_out_w`, `cfg_out_h`, `cfg_out_ch` in DIM_WIDTH each: output dimensions.
- `cfg_row_pitch`, `cfg_plane_pitch` in ADDR_WIDTH each: byte step per row / per channel plane.
- `aq_push` out 1, `aq_addr` out ADDR_WIDTH: FIFO write side.
- `aq_pop` out 1: FIFO pop.
- `aq_out_addr` in ADDR_WIDTH: FIFO output, valid the cycle after a pop.
- `res_valid` in 1, `res_data` in DATA_WIDTH, `res_ready` out 1: result handshake.
- `wr_valid` out 1, `wr_addr` out ADDR_WIDTH, `wr_data` out DATA_WIDTH, `wr_ready` in 1: memory write port.
- `busy` out 1, `done` out 1 (one-cycle pulse).

## Operation
- **Reset values.** All outputs reset to 0. The FSM resets to IDLE, the occupancy count and the generate/write counters reset to 0. The FIFO must share `rst`.
- **Main FSM: IDLE → GEN → DRAIN → IDLE.**
  - IDLE: `start` latches the configuration. If any dimension is 0, the FSM stays in IDLE and `done` pulses the next cycle with no pushes. Otherwise it moves to GEN.
  - GEN: when `occ < Q_DEPTH`, assert `aq_push` with the current address, then advance:
    - col+1 and address += ELEM_BYTES;
    - at end of row, reset col, row+1 and row_start += row_pitch;
    - at end of plane, reset row, ch+1 and plane_start += plane_pitch.
    - No multipliers are used.
    - After the last element is pushed, go to DRAIN.
  - DRAIN: when writes accepted equals W×H×C, pulse `done` and return to IDLE.
- **Writeback FSM: WB_IDLE → WB_POP → WB_WRITE.**
  - `res_ready = (main≠IDLE) & WB_IDLE & occ>0`.
  - `aq_pop = res_valid & res_ready` (combinational). On that handshake, capture `res_data` and go to WB_POP.
  - WB_POP: register `aq_out_addr` into `wr_addr`, then go to WB_WRITE.
  - WB_WRITE: hold `wr_valid`, `wr_addr` and `wr_data` stable until `wr_ready`, then return to WB_IDLE and increment the write counter.
- **Occupancy.** `occ` += `aq_push` − `aq_pop`. When both occur in the same cycle, `occ` is unchanged. The push gate uses the current `occ` only and never anticipates a same-cycle pop.
- **Widths.** Address arithmetic wraps modulo 2^ADDR_WIDTH. The element counter is 3·DIM_WIDTH bits.
- **Other rules.**
  - `start` while busy is ignored.
  - Configuration inputs are ignored outside IDLE.
  - `res_valid` while `res_ready` is low is not consumed.
- `busy` is high whenever main≠IDLE.

## Timing
- `start` high in IDLE at cycle 0 → `busy` and the first `aq_push` (addr = `cfg_base`) in cycle 1. With no backpressure, there is one push per cycle.
- Result handshake in cycle t → `aq_pop` in cycle t, `aq_out_addr` valid in cycle t+1, `wr_valid` high from cycle t+2.
- Write accepted in cycle u → `res_ready` may be high in cycle u+1. Peak throughput is one write every 3 cycles.
- Last write accepted in cycle u → `done`=1 and `busy`=0 in cycle u+1.
- `rst` asserted mid-operation → in the next cycle all outputs are 0, the FSM is IDLE, and in-flight results and addresses are discarded.

## Structure
- Shared package `conv_pkg`: main and WB state enums, and the default `ADDR_WIDTH`, `DATA_WIDTH`, `DIM_WIDTH` and `ELEM_BYTES` constants.
- One natural sub-module: `conv_out_addr_gen`, which holds the column/row/channel counters and the incremental pitch adders. It exposes `advance`, `addr`, `last`. The FSMs and the occupancy count stay in the top level.

## Test plan
- **Basic walk.** W=2, H=2, C=1, base 0x1000, row pitch 8, plane pitch 16, no backpressure, with a FIFO model. Expect pushes 0x1000, 0x1004, 0x1008, 0x100C in cycles 1–4. Four writes at those addresses carry their results in order. `done` pulses once.
- **FIFO full.** Q_DEPTH=4, 3×3×1, results withheld. Expect exactly 4 pushes, then `aq_push` stays low. After each result, one more push occurs. `occ` never exceeds 4.
- **Backpressure.** `wr_ready` held low for 5 cycles. Expect `wr_valid`, `wr_addr` and `wr_data` stable throughout, and `res_ready` low until acceptance.
- **Zero dimension and start while busy.** `cfg_out_h`=0 → `done` in cycle 1, no push or pop. A second `start` during a run is ignored (push count stays W×H×C).
- **Multi-channel.** 2×1×2, plane pitch 0x100 → addresses base, base+4, base+0x100, base+0x104.
- **Reset mid-run.** Assert `rst` after 3 writes. Next cycle all outputs are 0 and the FSM is IDLE. A fresh `start` then completes normally from `cfg_base`.
